// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Multi-cycle adder/subtractor. Operands are accepted in IDLE. In RUN the
// block adds one CHUNK-bit slice per cycle, LSB slice first, and carries
// between slices in a register. It then sits in DONE until the consumer
// takes the result. The result is ready WIDTH/CHUNK cycles after the
// accepting edge.
//
// Parameters
//   WIDTH      operand and result width in bits
//   CHUNK      bits added per cycle; WIDTH must be a non-zero multiple of it
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands present            in_ready   block in IDLE
//   A, B       operands                    carry_in   carry into bit 0 (add only)
//   sub        0 = A+B+carry_in, 1 = A-B
//   out_valid  result present (DONE)       out_ready  consumer takes result
//   sum        result                      carry_out  carry out of MSB (sub: 1 = no borrow)
//   overflow   two's-complement signed overflow
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N     = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("serial_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;      // already inverted in sub mode
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK:0]     chunk_res;     // {carry, CHUNK sum bits}
  logic               last_chunk;

  assign last_chunk = (cnt_q == CNT_W'(N - 1));

  // NOTE: every variable written here gets a default first; a path that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    a_chunk = '0;
    b_chunk = '0;

    // Constant-slice mux keeps the chunk select free of computed part-selects.
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        a_chunk = a_q[k*CHUNK +: CHUNK];
        b_chunk = b_q[k*CHUNK +: CHUNK];
      end
    end

    chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1: invert B now, seed the carry with 1.
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub | carry_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < N; k++) begin
          if (cnt_q == CNT_W'(k)) sum_d[k*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
        end
        carry_d = chunk_res[CHUNK];
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_chunk) begin
          cout_d  = chunk_res[CHUNK];
          // Carry into the MSB is a ^ b ^ s at that bit; overflow is that
          // XOR the carry out of it.
          ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ chunk_res[CHUNK-1] ^ chunk_res[CHUNK];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: operand registers are left unreset; they are always loaded on
  // accept before anything reads them.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Testbench for serial_adder (WIDTH=16, CHUNK=4). It runs directed and
// randomized operations and compares each result with a signed/unsigned
// arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle; drive and sample happen here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: {overflow, carry_out, sum[15:0]} from integer arithmetic.
  function automatic logic [17:0] ref_result(input logic [15:0] a, input logic [15:0] b,
                                             input logic cin, input logic sb);
    int          sa, sbv, ideal, ua, ub;
    logic        ovf, cout;
    logic [31:0] bits;
    sa  = $signed(a);
    sbv = $signed(b);
    ua  = int'({16'b0, a});
    ub  = int'({16'b0, b});
    if (sb) begin
      ideal = sa - sbv;
      cout  = (ua >= ub);
    end else begin
      ideal = sa + sbv + int'(cin);
      cout  = (ua + ub + int'(cin)) > 65535;
    end
    ovf  = (ideal > 32767) || (ideal < -32768);
    bits = ideal;
    return {ovf, cout, bits[15:0]};
  endfunction

  task automatic scramble_inputs();
    A        = WIDTH'($urandom);
    B        = WIDTH'($urandom);
    carry_in = 1'($urandom);
    sub      = 1'($urandom);
    in_valid = 1'($urandom);
  endtask

  // Step until out_valid rises or a budget expires; returns edges taken.
  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
      if (!out_valid) scramble_inputs();
    end
    check({tag, ":latency"}, 32'(lat), 32'(N));
  endtask

  // One full operation: accept, wait, check, hold with backpressure, release.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sb, input int hold);
    logic [17:0] exp;
    int          lat;
    exp = ref_result(a, b, cin, sb);
    check({tag, ":in_ready"}, 32'(in_ready), 32'd1);
    A = a; B = b; carry_in = cin; sub = sb; in_valid = 1'b1; out_ready = 1'b0;
    step();
    scramble_inputs();
    wait_done(tag, lat);
    check({tag, ":sum"}, 32'(sum), 32'(exp[15:0]));
    check({tag, ":carry_out"}, 32'(carry_out), 32'(exp[16]));
    check({tag, ":overflow"}, 32'(overflow), 32'(exp[17]));
    for (int i = 0; i < hold; i++) begin
      scramble_inputs();
      step();
      check({tag, ":hold"}, {13'b0, in_ready, out_valid, overflow, sum},
            {13'b0, 1'b0, 1'b1, exp[17], exp[15:0]});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, ":release"}, {14'b0, in_ready, out_valid, sum},
          {14'b0, 1'b1, 1'b0, exp[15:0]});
  endtask

  initial begin
    logic [17:0] exp;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; carry_in = 1'b0; sub = 1'b0;
    step();
    step();
    check("reset_state", {13'b0, in_ready, out_valid, carry_out, overflow, sum},
          {13'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});

    // Reset wins over a simultaneous accept.
    in_valid = 1'b1; A = 16'h00FF; B = 16'h0001;
    step();
    check("rst_priority", 32'(in_ready), 32'd1);
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    check("rst_priority_idle", 32'(in_ready), 32'd1);

    // Directed cases.
    run_op("add_basic",   16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    run_op("ripple_b1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
    run_op("ripple_cin",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
    run_op("signed_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op("sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    run_op("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    run_op("sub_equal",   16'hABCD, 16'hABCD, 1'b0, 1'b1, 2);

    // Backpressure with new operands waiting.
    begin
      int lat;
      A = 16'h1111; B = 16'h2222; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_done("bp_first", lat);
      A = 16'h0F0F; B = 16'h0101; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
        step();
        check("bp_hold", {14'b0, in_ready, out_valid, sum}, {14'b0, 1'b0, 1'b1, 16'h3333});
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_release", {30'b0, in_ready, out_valid}, {30'b0, 1'b1, 1'b0});
      step();
      in_valid = 1'b0;
      check("bp_accepted", 32'(in_ready), 32'd0);
      for (int i = 0; i < N - 1; i++) step();
      check("bp_not_early", 32'(out_valid), 32'd0);
      step();
      check("bp_second", {15'b0, out_valid, sum}, {15'b0, 1'b1, 16'h1010});
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end

    // Reset during RUN aborts the operation.
    begin
      int seen;
      A = 16'h1234; B = 16'h4321; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      check("abort_state", {13'b0, in_ready, out_valid, carry_out, overflow, sum},
            {13'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 2 * N; i++) begin
        step();
        if (out_valid) seen++;
      end
      check("abort_no_valid", 32'(seen), 32'd0);
    end

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      run_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, 16, operand and result width in bits.
REQ-002 Parameter: CHUNK, 4, bits added per clock cycle; N = WIDTH/CHUNK chunks per operation.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: in_valid  input  1  operands present.
REQ-006 Port: in_ready  output  1  block can accept operands.
REQ-007 Port: A  input  WIDTH  first operand.
REQ-008 Port: B  input  WIDTH  second operand.
REQ-009 Port: carry_in  input  1  carry into bit 0 (add mode only).
REQ-010 Port: sub  input  1  0 = add, 1 = subtract.
REQ-011 Port: out_valid  output  1  result present.
REQ-012 Port: out_ready  input  1  consumer accepts result.
REQ-013 Port: sum  output  WIDTH  result.
REQ-014 Port: carry_out  output  1  carry out of bit WIDTH-1.
REQ-015 Port: overflow  output  1  two's-complement signed overflow.

Function
REQ-016 WIDTH SHALL be a non-zero multiple of CHUNK; CHUNK >= 1; otherwise elaboration SHALL fail.
REQ-017 FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-019 IDLE: a rising edge with in_valid=1 SHALL latch A, B, carry_in and sub, clear the chunk counter and enter RUN.
REQ-020 Operand effective values: add: A + B + carry_in; sub: A + ~B + 1 (carry_in ignored).
REQ-021 RUN: each cycle SHALL add chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) of both operands plus the stored inter-chunk carry, write sum chunk k and update the carry, for k = 0 .. N-1, LSB chunk first.
REQ-022 After chunk N-1 is written, the FSM SHALL enter DONE, so out_valid rises exactly N cycles after the accepting edge.
REQ-023 carry_out SHALL equal the carry out of bit WIDTH-1; in sub mode, 1 means no borrow.
REQ-024 overflow SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-025 DONE: sum, carry_out and overflow SHALL hold stable until the edge where out_ready=1, which SHALL return the FSM to IDLE.
REQ-026 There SHALL be no same-cycle accept in DONE; minimum issue interval is N+2 cycles with out_ready held at 1.
REQ-027 Changes on A, B, carry_in, sub or in_valid outside IDLE SHALL have no effect.
REQ-028 For CHUNK = WIDTH (N=1), RUN SHALL last one cycle.
REQ-029 sum SHALL retain the last result through IDLE until the next RUN overwrites it.

Reset
REQ-030 A rising edge with rst_n=0 SHALL force IDLE and set sum=0, carry_out=0, overflow=0, out_valid=0, in_ready=1, and clear the inter-chunk carry and counter.
REQ-031 Reset during RUN or DONE SHALL abort the operation; no out_valid SHALL appear for it.
REQ-032 rst_n=0 SHALL take priority over all handshakes in the same cycle.

Verification (WIDTH=16, CHUNK=4)
REQ-033 Add: A=0x1234, B=0x4321, carry_in=0, sub=0 -> out_valid 4 cycles after accept; sum=0x5555, carry_out=0, overflow=0.
REQ-034 Full carry ripple: A=0xFFFF, B=0x0001, carry_in=0 -> sum=0x0000, carry_out=1, overflow=0; A=0xFFFF, B=0x0000, carry_in=1 -> same result.
REQ-035 Signed overflow: A=0x7FFF, B=0x0001, sub=0 -> sum=0x8000, carry_out=0, overflow=1.
REQ-036 Subtract: A=0x0005, B=0x0007, sub=1, carry_in=1 -> sum=0xFFFE, carry_out=0, overflow=0 (carry_in ignored).
REQ-037 Backpressure: hold out_ready=0 for 3 cycles in DONE with in_valid=1 and new operands -> outputs unchanged and in_ready=0; after out_ready=1, in_ready=1 on the next cycle and the new operands are accepted only then.
REQ-038 Reset mid-operation: drive rst_n=0 on RUN cycle 2 -> next cycle: in_ready=1, out_valid=0, sum=0x0000; out_valid does not assert for the aborted operation.
